bios_host: RTL and testbench

Host-side command initiator for the BIOS byte-stream command protocol. It serializes one ASCII command word (`nop`, `boot`, `write`, `read`) onto an outgoing byte stream and then waits for the single-byte reply from the BIOS command parser. It classifies that reply into a status code. It sits on the host/test side of the UART byte path and drives the stream the BIOS block consumes.

---
 rtl/bios_host.sv | 192 +++++++++++++++++++
 tb/tb_bios_host.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_host.sv
// bios_host: host-side command initiator for the BIOS byte-stream protocol.
// Serializes an ASCII command word, waits for a one-byte reply and
// classifies it into a status code.
// Optional reply timeout: define BIOS_HOST_TIMEOUT_EN to build the WAIT counter.
module bios_host #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [2:0] i_cmd,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_out_ready,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_in_ready,
    output logic       o_rsp_valid,
    output logic [2:0] o_rsp_status,
    output logic [7:0] o_rsp_code
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_BADCMD  = 3'd1;
    localparam logic [2:0] ST_EXCEPT  = 3'd2;
    localparam logic [2:0] ST_UNKNOWN = 3'd3;
    localparam logic [2:0] ST_UNEXP   = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;
    localparam logic [2:0] ST_ILLEGAL = 3'd6;

    state_t     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] status_q, status_d;
    logic [7:0] code_q, code_d;
    logic       timeout_hit;

`ifdef BIOS_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q, tmo_d;
    // The edge that would bring the count to TIMEOUT_CYCLES ends the wait.
    assign timeout_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Byte string of each command word, indexed by position.
    function automatic logic [7:0] cmd_byte(input logic [1:0] c, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case ({c, i})
            {2'd0, 3'd0}: b = 8'h6E;
            {2'd0, 3'd1}: b = 8'h6F;
            {2'd0, 3'd2}: b = 8'h70;
            {2'd1, 3'd0}: b = 8'h62;
            {2'd1, 3'd1}: b = 8'h6F;
            {2'd1, 3'd2}: b = 8'h6F;
            {2'd1, 3'd3}: b = 8'h74;
            {2'd2, 3'd0}: b = 8'h77;
            {2'd2, 3'd1}: b = 8'h72;
            {2'd2, 3'd2}: b = 8'h69;
            {2'd2, 3'd3}: b = 8'h74;
            {2'd2, 3'd4}: b = 8'h65;
            {2'd3, 3'd0}: b = 8'h72;
            {2'd3, 3'd1}: b = 8'h65;
            {2'd3, 3'd2}: b = 8'h61;
            {2'd3, 3'd3}: b = 8'h64;
            default:      b = 8'h00;
        endcase
        return b;
    endfunction

    // Index of the final byte of each command word.
    function automatic logic [2:0] last_idx(input logic [1:0] c);
        case (c)
            2'd0:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    // Reply classification; the ack letter is the upper-case first letter.
    function automatic logic [2:0] classify(input logic [1:0] c, input logic [7:0] r);
        logic [7:0] ack;
        case (c)
            2'd0:    ack = 8'h4E;
            2'd1:    ack = 8'h42;
            2'd2:    ack = 8'h57;
            default: ack = 8'h52;
        endcase
        if (r == ack)       return ST_OK;
        else if (r == 8'h45) return ST_BADCMD;
        else if (r == 8'h58) return ST_EXCEPT;
        else if (r == 8'h30) return ST_UNKNOWN;
        else                 return ST_UNEXP;
    endfunction

    // State register: synchronous reset, otherwise update only on enabled edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= 2'd0;
            idx_q    <= 3'd0;
            status_q <= 3'd0;
            code_q   <= 8'h00;
`ifdef BIOS_HOST_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else if (clk_en) begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            code_q   <= code_d;
`ifdef BIOS_HOST_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Next-state logic: command accept, byte sequencing, reply classification.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        idx_d    = idx_q;
        status_d = status_q;
        code_d   = code_q;
`ifdef BIOS_HOST_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd[2]) begin
                        state_d  = S_DONE;
                        status_d = ST_ILLEGAL;
                        code_d   = 8'h00;
                    end else begin
                        state_d = S_SEND;
                        cmd_d   = i_cmd[1:0];
                        idx_d   = 3'd0;
                    end
                end
            end
            S_SEND: begin
                if (i_out_ready) begin
                    if (idx_q == last_idx(cmd_q)) begin
                        state_d = S_WAIT;
`ifdef BIOS_HOST_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_WAIT: begin
                if (i_valid) begin
                    state_d  = S_DONE;
                    code_d   = i_data;
                    status_d = classify(cmd_q, i_data);
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    code_d   = 8'h00;
                    status_d = ST_TIMEOUT;
                end else begin
`ifdef BIOS_HOST_TIMEOUT_EN
                    tmo_d = tmo_q + CW'(1);
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        o_cmd_ready  = (state_q == S_IDLE);
        o_valid      = (state_q == S_SEND);
        o_data       = (state_q == S_SEND) ? cmd_byte(cmd_q, idx_q) : 8'h00;
        o_in_ready   = (state_q == S_WAIT);
        o_rsp_valid  = (state_q == S_DONE);
        o_rsp_status = status_q;
        o_rsp_code   = code_q;
    end

endmodule

// File: tb/tb_bios_host.sv
// Self-checking bench for bios_host: directed scenarios plus randomized
// commands, replies, stalls and clock-enable gaps, checked against a
// string-based reference model of the protocol.
module tb_bios_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic [2:0] i_cmd = 3'd0;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_out_ready = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_in_ready;
    logic       o_rsp_valid;
    logic [2:0] o_rsp_status;
    logic [7:0] o_rsp_code;

    int checks = 0;
    int errors = 0;

    bios_host #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
        .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_status(o_rsp_status), .o_rsp_code(o_rsp_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: command words as text; ack is the capitalised first letter.
    function automatic string name_of(input int c);
        case (c)
            0: return "nop";
            1: return "boot";
            2: return "write";
            default: return "read";
        endcase
    endfunction

    function automatic logic [7:0] ack_of(input int c);
        string u;
        u = name_of(c);
        u = u.toupper();
        return u[0];
    endfunction

    function automatic logic [2:0] expect_status(input int c, input logic [7:0] r);
        if (r == ack_of(c)) return 3'd0;
        if (r == "E")       return 3'd1;
        if (r == "X")       return 3'd2;
        if (r == "0")       return 3'd3;
        return 3'd4;
    endfunction

    // Accept a legal command; rdy_mode 0=always,1=toggle,2=random; en_mode 0=always,1=1,0,0,1 pattern,2=random.
    task automatic run_legal(input int c, input logic [7:0] reply, input int rdy_mode, input int en_mode);
        string s;
        int idx, k, hs, w, d;
        logic rdy, en;
        logic [2:0] st;
        logic [3:0] pat;
        pat = 4'b1001;
        s = name_of(c);
        chk("idle_ready", o_cmd_ready, 1);
        i_cmd = 3'(c); i_cmd_valid = 1'b1; clk_en = 1'b1;
        tick();
        i_cmd_valid = 1'b0; i_cmd = 3'($urandom_range(0, 7));
        idx = 0; k = 0; hs = 0;
        while (idx < s.len() && k < 200) begin
            chk("send_valid", o_valid, 1);
            chk("send_data", o_data, {24'h0, s[idx]});
            chk("send_in_ready", o_in_ready, 0);
            chk("send_cmd_ready", o_cmd_ready, 0);
            rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            en  = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? pat[3 - (k % 4)] : ($urandom_range(0, 3) != 0);
            i_out_ready = rdy; clk_en = en;
            i_valid = 1'b1; i_data = 8'($urandom);   // stray reply bytes must be ignored
            tick();
            if (rdy && en) begin idx++; hs++; end
            k++;
        end
        chk("send_budget", (k < 200), 1);
        chk("handshakes", hs, s.len());
        i_valid = 1'b0; i_out_ready = 1'b0;
        chk("wait_valid", o_valid, 0);
        chk("wait_in_ready", o_in_ready, 1);
        w = $urandom_range(0, 3);
        for (int j = 0; j < w; j++) begin
            clk_en = 1'($urandom_range(0, 1));
            tick();
            chk("wait_hold", {o_in_ready, o_rsp_valid}, 2'b10);
        end
        i_valid = 1'b1; i_data = reply; clk_en = 1'b1;
        tick();
        i_valid = 1'b0;
        st = expect_status(c, reply);
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_status", o_rsp_status, st);
        chk("rsp_code", o_rsp_code, reply);
        chk("done_in_ready", o_in_ready, 0);
        d = (en_mode == 0) ? 0 : $urandom_range(0, 2);
        for (int j = 0; j < d; j++) begin
            clk_en = 1'b0;
            tick();
            chk("rsp_valid_held", o_rsp_valid, 1);
        end
        clk_en = 1'b1;
        tick();
        chk("rsp_pulse_end", o_rsp_valid, 0);
        chk("ready_again", o_cmd_ready, 1);
        chk("status_hold", o_rsp_status, st);
        chk("code_hold", o_rsp_code, reply);
        $display("txn cmd=%s reply=%02h status=%0d code=%02h", s, reply, o_rsp_status, o_rsp_code);
    endtask

    task automatic run_illegal(input int c);
        clk_en = 1'b1; i_cmd = 3'(c); i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        chk("ill_no_valid", o_valid, 0);
        chk("ill_rsp_valid", o_rsp_valid, 1);
        chk("ill_status", o_rsp_status, 6);
        chk("ill_code", o_rsp_code, 0);
        tick();
        chk("ill_ready", o_cmd_ready, 1);
        chk("ill_pulse_end", o_rsp_valid, 0);
        $display("txn cmd=%0d illegal status=%0d", c, o_rsp_status);
    endtask

    task automatic send_boot();
        clk_en = 1'b1; i_cmd = 3'd1; i_cmd_valid = 1'b1; i_out_ready = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        repeat (4) tick();
        i_out_ready = 1'b0;
        chk("boot_in_wait", o_in_ready, 1);
    endtask

    logic [7:0] rr;
    int cnt, seen;

    initial begin
        // reset state
        rst = 1'b1; clk_en = 1'b1;
        tick(); tick();
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_status", o_rsp_status, 0);
        chk("rst_code", o_rsp_code, 0);
        rst = 1'b0;

        run_legal(0, 8'h4E, 0, 0);
        run_legal(2, 8'h45, 1, 0);
        run_legal(3, 8'h42, 0, 0);
        run_illegal(5);

        // reset mid-write after two bytes
        clk_en = 1'b1; i_cmd = 3'd2; i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0; i_out_ready = 1'b1;
        tick(); tick();
        chk("mid_write_data", o_data, 8'h69);
        rst = 1'b1;
        tick();
        rst = 1'b0; i_out_ready = 1'b0;
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_ready", o_cmd_ready, 1);
        chk("rst_mid_rsp", o_rsp_valid, 0);
        chk("rst_mid_status", o_rsp_status, 0);
        chk("rst_mid_code", o_rsp_code, 0);
        $display("txn write aborted by reset");
        run_legal(0, 8'h4E, 0, 0);

        // clock-enable gaps during nop
        run_legal(0, 8'h58, 0, 1);

`ifdef BIOS_HOST_TIMEOUT_EN
        send_boot();
        cnt = 0;
        while (!o_rsp_valid && cnt < 50) begin tick(); cnt++; end
        chk("tmo_cycles", cnt, 8);
        chk("tmo_status", o_rsp_status, 5);
        chk("tmo_code", o_rsp_code, 0);
        tick();
        $display("txn boot timeout after %0d cycles", cnt);
        send_boot();
        repeat (7) tick();
        chk("tmo_not_yet", o_rsp_valid, 0);
        i_valid = 1'b1; i_data = 8'h42;
        tick();
        i_valid = 1'b0;
        chk("tmo_race_status", o_rsp_status, 0);
        chk("tmo_race_code", o_rsp_code, 8'h42);
        tick();
        $display("txn boot reply on timeout edge status=%0d", o_rsp_status);
`else
        send_boot();
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (o_rsp_valid || !o_in_ready) seen++;
        end
        chk("no_timeout", seen, 0);
        i_valid = 1'b1; i_data = 8'h42;
        tick();
        i_valid = 1'b0;
        chk("late_reply_status", o_rsp_status, 0);
        chk("late_reply_code", o_rsp_code, 8'h42);
        tick();
        $display("txn boot long wait status=%0d", o_rsp_status);
`endif

        // randomized commands and replies
        for (int t = 0; t < 40; t++) begin
            int c;
            c = $urandom_range(0, 7);
            if (c > 3) run_illegal(c);
            else begin
                case ($urandom_range(0, 5))
                    0: rr = ack_of(c);
                    1: rr = ack_of((c + 1) % 4);
                    2: rr = "E";
                    3: rr = "X";
                    4: rr = "0";
                    default: rr = 8'($urandom);
                endcase
                run_legal(c, rr, 2, 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
